// File: rtl/user_fifo_bridge_pkg.sv
// Shared types and constants for the user FIFO host bridge: FSM state encoding,
// register byte addresses and the data word returned when an RX access times out.
package user_fifo_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_WAIT = 2'd1,
    RX_WAIT = 2'd2,
    ACK     = 2'd3
  } bridge_state_e;

  localparam logic [7:0] ADDR_TX     = 8'h00;
  localparam logic [7:0] ADDR_RX     = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CTRL   = 8'h0C;
  localparam logic [7:0] ADDR_TXCNT  = 8'h14;
  localparam logic [7:0] ADDR_RXCNT  = 8'h18;

  localparam logic [31:0] RX_TIMEOUT_PATTERN = 32'hDEAD_0000;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Wait-state timeout down-counter for the FIFO host bridge: reloaded on entry to a
// wait state, decremented while enabled, expired once it reaches zero.
module bridge_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The first wait cycle sees the loaded value, so loading N-1 expires on wait cycle N.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/user_fifo_host_bridge.sv
// Host-side bridge from single-beat register accesses to the user FIFO pair.
// Optional TX/RX word counters are built when USER_FIFO_BRIDGE_STATS_EN is defined.
//
// state   | meaning
// IDLE    | accept and decode a register request
// TX_WAIT | input FIFO full, waiting to push or time out
// RX_WAIT | output FIFO empty, waiting to pop or time out
// ACK     | one-cycle completion, push/pop pulse and read data presented
module user_fifo_host_bridge
  import user_fifo_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_cfg_wr,
  input  logic                  i_cfg_rd,
  input  logic [7:0]            i_cfg_addr,
  input  logic [DATA_WIDTH-1:0] i_cfg_wdata,
  output logic [DATA_WIDTH-1:0] o_cfg_rdata,
  output logic                  o_cfg_ack,
  input  logic                  i_in_full,
  output logic                  o_in_wr,
  output logic [DATA_WIDTH-1:0] o_in_dout,
  input  logic                  i_out_empty,
  output logic                  o_out_rd,
  input  logic [DATA_WIDTH-1:0] i_out_din
);

  bridge_state_e r_state, w_state_nxt;

  logic                  r_ack, r_in_wr, r_out_rd;
  logic [DATA_WIDTH-1:0] r_rdata, r_in_dout;
  logic [CNT_W-1:0]      r_outstanding;
  logic                  r_err_unf, r_err_tmo;

  logic                  w_ack_nxt, w_wr_nxt, w_rd_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt, w_reg_rdata, w_status;
  logic                  w_dout_load, w_clr, w_set_tmo, w_tmo_load, w_tmo_en, w_tmo_expired;
  logic [CNT_W-1:0]      w_tx_cnt, w_rx_cnt;

  assign w_tmo_en = (r_state == TX_WAIT) || (r_state == RX_WAIT);

  bridge_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_tmo_load),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_expired)
  );

  always_comb begin
    w_status                = '0;
    w_status[16 +: CNT_W]   = r_outstanding;
    w_status[3]             = r_err_unf;
    w_status[2]             = r_err_tmo;
    w_status[1]             = !i_out_empty;
    w_status[0]             = i_in_full;
  end

  always_comb begin
    case (i_cfg_addr)
      ADDR_STATUS: w_reg_rdata = w_status;
      ADDR_TXCNT:  w_reg_rdata = DATA_WIDTH'(w_tx_cnt);
      ADDR_RXCNT:  w_reg_rdata = DATA_WIDTH'(w_rx_cnt);
      default:     w_reg_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_rdata_nxt = '0;
    w_dout_load = 1'b0;
    w_clr       = 1'b0;
    w_set_tmo   = 1'b0;
    w_tmo_load  = 1'b0;
    case (r_state)
      IDLE: begin
        // A write wins over a simultaneous read; the read is simply not served.
        if (i_cfg_wr) begin
          if (i_cfg_addr == ADDR_TX) begin
            w_dout_load = 1'b1;
            if (!i_in_full) begin
              w_state_nxt = ACK;
              w_ack_nxt   = 1'b1;
              w_wr_nxt    = 1'b1;
            end else begin
              w_state_nxt = TX_WAIT;
              w_tmo_load  = 1'b1;
            end
          end else begin
            w_clr       = (i_cfg_addr == ADDR_CTRL) && i_cfg_wdata[0];
            w_state_nxt = ACK;
            w_ack_nxt   = 1'b1;
          end
        end else if (i_cfg_rd) begin
          if (i_cfg_addr == ADDR_RX) begin
            if (!i_out_empty) begin
              w_state_nxt = ACK;
              w_ack_nxt   = 1'b1;
              w_rd_nxt    = 1'b1;
              w_rdata_nxt = i_out_din;
            end else begin
              w_state_nxt = RX_WAIT;
              w_tmo_load  = 1'b1;
            end
          end else begin
            w_state_nxt = ACK;
            w_ack_nxt   = 1'b1;
            w_rdata_nxt = w_reg_rdata;
          end
        end
      end
      TX_WAIT: begin
        if (!i_in_full) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          w_wr_nxt    = 1'b1;
        end else if (w_tmo_expired) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          w_set_tmo   = 1'b1;
        end
      end
      RX_WAIT: begin
        if (!i_out_empty) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          w_rd_nxt    = 1'b1;
          w_rdata_nxt = i_out_din;
        end else if (w_tmo_expired) begin
          w_state_nxt = ACK;
          w_ack_nxt   = 1'b1;
          w_set_tmo   = 1'b1;
          w_rdata_nxt = DATA_WIDTH'(RX_TIMEOUT_PATTERN);
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_in_wr   <= 1'b0;
      r_out_rd  <= 1'b0;
      r_rdata   <= '0;
      r_in_dout <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_in_wr  <= w_wr_nxt;
      r_out_rd <= w_rd_nxt;
      r_rdata  <= w_rdata_nxt;
      if (w_dout_load) r_in_dout <= i_cfg_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || w_clr) begin
      r_outstanding <= '0;
      r_err_unf     <= 1'b0;
      r_err_tmo     <= 1'b0;
    end else begin
      if (w_set_tmo) r_err_tmo <= 1'b1;
      if (r_in_wr) begin
        if (r_outstanding != {CNT_W{1'b1}}) r_outstanding <= r_outstanding + CNT_W'(1);
      end else if (r_out_rd) begin
        if (r_outstanding != '0) r_outstanding <= r_outstanding - CNT_W'(1);
        else                     r_err_unf     <= 1'b1;
      end
    end
  end

`ifdef USER_FIFO_BRIDGE_STATS_EN
  logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n || w_clr) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (r_in_wr)  r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      if (r_out_rd) r_rx_cnt <= r_rx_cnt + CNT_W'(1);
    end
  end

  assign w_tx_cnt = r_tx_cnt;
  assign w_rx_cnt = r_rx_cnt;
`else
  assign w_tx_cnt = '0;
  assign w_rx_cnt = '0;
`endif

  assign o_cfg_ack   = r_ack;
  assign o_cfg_rdata = r_rdata;
  assign o_in_wr     = r_in_wr;
  assign o_in_dout   = r_in_dout;
  assign o_out_rd    = r_out_rd;

endmodule

// File: tb/tb_user_fifo_host_bridge.sv
// Directed bench for user_fifo_host_bridge: expected completions are queued when an
// access is issued and compared when the bridge acknowledges it.
module tb_user_fifo_host_bridge;

  localparam int T = 1023;

  typedef struct {
    logic [31:0] rdata;
    logic        in_wr;
    logic        out_rd;
    int          lat;
    logic [31:0] dout;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_cfg_wr = 1'b0, i_cfg_rd = 1'b0;
  logic [7:0]  i_cfg_addr = '0;
  logic [31:0] i_cfg_wdata = '0;
  logic [31:0] o_cfg_rdata;
  logic        o_cfg_ack;
  logic        i_in_full = 1'b0;
  logic        o_in_wr;
  logic [31:0] o_in_dout;
  logic        i_out_empty = 1'b1;
  logic        o_out_rd;
  logic [31:0] i_out_din = '0;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  user_fifo_host_bridge #(.DATA_WIDTH(32), .CNT_W(16), .TIMEOUT_CYCLES(T)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_cfg_wr    (i_cfg_wr),
    .i_cfg_rd    (i_cfg_rd),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_wdata (i_cfg_wdata),
    .o_cfg_rdata (o_cfg_rdata),
    .o_cfg_ack   (o_cfg_ack),
    .i_in_full   (i_in_full),
    .o_in_wr     (o_in_wr),
    .o_in_dout   (o_in_dout),
    .i_out_empty (i_out_empty),
    .o_out_rd    (o_out_rd),
    .i_out_din   (i_out_din)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status(input int outst, input bit unf, input bit tmo,
                                         input bit oe, input bit full);
    return {outst[15:0], 12'd0, unf, tmo, ~oe, full};
  endfunction

  // release_after > 0: drop the relevant FIFO stall after that many cycles.
  task automatic access(input string tag, input bit wr, input bit rd, input logic [7:0] addr,
                        input logic [31:0] wdata, input int release_after, input exp_t e);
    int   n = 0;
    int   stray = 0;
    bit   got = 0;
    exp_t x;
    sb_q.push_back(e);
    i_cfg_wr = wr;
    i_cfg_rd = rd;
    i_cfg_addr = addr;
    i_cfg_wdata = wdata;
    while (!got && n < T + 20) begin
      tick();
      n++;
      i_cfg_wr = 1'b0;
      i_cfg_rd = 1'b0;
      if (o_cfg_ack) begin
        got = 1;
        x = sb_q.pop_front();
        check({tag, "_lat"}, n, x.lat);
        check({tag, "_rdata"}, o_cfg_rdata, x.rdata);
        check({tag, "_in_wr"}, {31'd0, o_in_wr}, {31'd0, x.in_wr});
        check({tag, "_out_rd"}, {31'd0, o_out_rd}, {31'd0, x.out_rd});
        if (x.in_wr) check({tag, "_in_dout"}, o_in_dout, x.dout);
      end else if (o_in_wr || o_out_rd) begin
        stray++;
      end
      if (n == release_after) begin
        if (wr) i_in_full = 1'b0;
        else    i_out_empty = 1'b0;
      end
    end
    check({tag, "_acked"}, {31'd0, got}, 32'd1);
    if (!got) void'(sb_q.pop_front());
    tick();
    check({tag, "_ack_pulse"}, {29'd0, o_cfg_ack, o_in_wr, o_out_rd}, 32'd0);
    check({tag, "_stray"}, stray, 0);
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input bit w, input bit r,
                              input int lat, input logic [31:0] dout);
    exp_t e;
    e.rdata = rdata; e.in_wr = w; e.out_rd = r; e.lat = lat; e.dout = dout;
    return e;
  endfunction

  initial begin
    int pulses;
    repeat (3) tick();
    check("rst_outputs", {o_cfg_ack, o_in_wr, o_out_rd}, 3'b000);
    check("rst_rdata", o_cfg_rdata, 32'd0);
    check("rst_in_dout", o_in_dout, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: push with room available
    access("t1_tx", 1, 0, 8'h00, 32'h0000_1A2B, 0, mk(0, 1, 0, 1, 32'h0000_1A2B));
    access("t1_status", 0, 1, 8'h08, 0, 0, mk(status(1, 0, 0, 1, 0), 0, 0, 1, 0));

    // 2: pop with data available
    i_out_din = 32'h0000_005C;
    i_out_empty = 1'b0;
    access("t2_rx", 0, 1, 8'h04, 0, 0, mk(32'h0000_005C, 0, 1, 1, 0));
    i_out_empty = 1'b1;
    access("t2_status", 0, 1, 8'h08, 0, 0, mk(status(0, 0, 0, 1, 0), 0, 0, 1, 0));

    // 3: full FIFO released after 10 cycles
    i_in_full = 1'b1;
    access("t3_tx", 1, 0, 8'h00, 32'h0000_CAFE, 10, mk(0, 1, 0, 11, 32'h0000_CAFE));
    access("t3_status", 0, 1, 8'h08, 0, 0, mk(status(1, 0, 0, 1, 0), 0, 0, 1, 0));

    // 4: RX timeout, then clear
    access("t4_rx_tmo", 0, 1, 8'h04, 0, 0, mk(32'hDEAD_0000, 0, 0, T + 1, 0));
    access("t4_status", 0, 1, 8'h08, 0, 0, mk(status(1, 0, 1, 1, 0), 0, 0, 1, 0));
    access("t4_ctrl", 1, 0, 8'h0C, 32'h1, 0, mk(0, 0, 0, 1, 0));
    access("t4_status_clr", 0, 1, 8'h08, 0, 0, mk(status(0, 0, 0, 1, 0), 0, 0, 1, 0));

    // 5: underflow pop
    i_out_din = 32'h0000_0077;
    i_out_empty = 1'b0;
    access("t5_rx", 0, 1, 8'h04, 0, 0, mk(32'h0000_0077, 0, 1, 1, 0));
    access("t5_status", 0, 1, 8'h08, 0, 0, mk(status(0, 1, 0, 0, 0), 0, 0, 1, 0));

    // Simultaneous write/read: write to RX is ignored, read is dropped
    access("both_req", 1, 1, 8'h04, 32'h1234, 0, mk(0, 0, 0, 1, 0));
    i_out_empty = 1'b1;
    access("unmapped_rd", 0, 1, 8'h20, 0, 0, mk(0, 0, 0, 1, 0));
    access("unmapped_wr", 1, 0, 8'h10, 32'hFFFF_FFFF, 0, mk(0, 0, 0, 1, 0));
    access("t5_status2", 0, 1, 8'h08, 0, 0, mk(status(0, 1, 0, 1, 0), 0, 0, 1, 0));
    access("t5_ctrl", 1, 0, 8'h0C, 32'h1, 0, mk(0, 0, 0, 1, 0));

    // 6: reset while stalled in TX_WAIT
    pulses = 0;
    i_in_full = 1'b1;
    i_cfg_wr = 1'b1;
    i_cfg_addr = 8'h00;
    i_cfg_wdata = 32'h0000_BEEF;
    tick();
    i_cfg_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (o_cfg_ack || o_in_wr) pulses++;
      tick();
    end
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (o_cfg_ack || o_in_wr) pulses++;
    end
    reset_n = 1'b1;
    i_in_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_cfg_ack || o_in_wr) pulses++;
    end
    check("t6_no_pulse", pulses, 0);
    check("t6_in_dout_rst", o_in_dout, 32'd0);
    access("t6_tx", 1, 0, 8'h00, 32'h0000_5678, 0, mk(0, 1, 0, 1, 32'h0000_5678));
`ifdef USER_FIFO_BRIDGE_STATS_EN
    access("t6_txcnt", 0, 1, 8'h14, 0, 0, mk(32'd1, 0, 0, 1, 0));
`else
    access("t6_txcnt", 0, 1, 8'h14, 0, 0, mk(32'd0, 0, 0, 1, 0));
`endif
    access("t6_rxcnt", 0, 1, 8'h18, 0, 0, mk(32'd0, 0, 0, 1, 0));
    access("t6_status", 0, 1, 8'h08, 0, 0, mk(status(1, 0, 0, 1, 0), 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
